// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: one bit per cycle for
// MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO, busy/done for pipeline stalls.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]     operand;   // multiplicand or divisor magnitude
  logic                 is_div;
  logic                 neg_main;  // negate product or quotient
  logic                 neg_rem;
  logic                 div_zero;

  logic                 op_signed;
  logic                 op_div;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign abs_a     = (op_signed && in1[WIDTH-1]) ? -in1 : in1;
  assign abs_b     = (op_signed && in2[WIDTH-1]) ? -in2 : in2;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_next;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, operand};
  // Restoring step: keep the shifted remainder when the trial subtraction borrows.
  assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign prod_fix = neg_main ? -acc : acc;
  // A zero divisor leaves quotient all ones and remainder = |dividend|, which
  // sign-corrects back to the dividend; only the quotient needs overriding.
  assign quot_fix = div_zero ? '1 : (neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op >= OP_MULT && op <= OP_DIVU) begin
              is_div   <= op_div;
              neg_main <= op_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
              neg_rem  <= op_signed && in1[WIDTH-1];
              div_zero <= op_div && (in2 == '0);
              operand  <= op_div ? abs_b : abs_a;
              acc      <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
              cnt      <= CNT_W'(WIDTH);
              busy     <= 1'b1;
              state    <= RUN;
            end else if (op == OP_MTHI) begin
              hi   <= in1;
              done <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo   <= in1;
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle multiply unit; owns the HI/LO register pair.
- Executes signed and unsigned multiply and divide iteratively, one bit per cycle.
- Executes MTHI/MTLO in a single cycle.
- Exposes busy/done so the processor stalls PC advance and mfhi/mflo while an operation is in flight.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO; any value >= 4.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
in1  input  WIDTH  rs operand / multiplicand / dividend / MTHI-MTLO source
in2  input  WIDTH  rt operand / multiplier / divisor
busy  output  1  operation in flight; processor must stall
done  output  1  one-cycle pulse; HI/LO updated on this cycle's preceding edge
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any time including mid-operation): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, working registers cleared. No partial result is committed.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 with op 1-4: latch operands, compute |in1| and |in2| for the signed ops, record result signs, set counter=WIDTH, go to RUN. busy=1 from this edge.
  - start=1 with op 5: hi<=in1 on the same edge; stay in IDLE; busy stays 0; done pulses 1.
  - start=1 with op 6: lo<=in1 on the same edge; stay in IDLE; busy stays 0; done pulses 1.
  - op 0 or 7: no effect.
- RUN: one iteration per edge; counter decrements; after WIDTH iterations (counter reaches 0) go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division.
- FIX (one edge):
  - Apply sign correction and write hi/lo.
  - Go to IDLE; busy falls and done=1 for exactly one cycle.
- Latency: accept edge k; hi/lo valid after edge k+WIDTH+1 (33 edges for WIDTH=32); busy high for WIDTH+1 cycles.
- Multiply: {hi,lo} = full 2*WIDTH product. MULT is two's-complement signed; MULTU is unsigned.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
- Divide by zero (DIV or DIVU): lo = all ones, hi = in1 (dividend unchanged). No exception is raised.
- Signed overflow (DIV of most-negative value by -1): lo = most-negative value, hi = 0.
- start while busy=1 is ignored entirely; the in-flight operation is unaffected and no request is queued.
- Operands are captured at accept; changes to in1/in2 during RUN have no effect.
- hi/lo hold their previous values during RUN and FIX until the commit edge.
- done and busy are never high in the same cycle.

Test Plan:
- MULTU in1=0xFFFFFFFF, in2=0xFFFFFFFF -> after 33 edges: hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy high for exactly 33 cycles.
- MULT in1=-3 (0xFFFFFFFD), in2=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV in1=-7, in2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU in1=10, in2=0 -> lo=0xFFFFFFFF, hi=0x0000000A.
- MTHI in1=0x12345678 -> hi=0x12345678 after one edge, busy stays 0, done pulses. Then DIVU 100/7 with a second start (MULT 2*2) at cycle 5 -> second start ignored; lo=14, hi=2.
- Start MULTU 6*7, assert rst at cycle 10 -> busy=0, hi=lo=0 immediately; no done pulse. Then a new MULTU 6*7 -> lo=42, hi=0.
